// File: rtl/irq_seq_pkg.sv
// Shared definitions for the CPU-side interrupt sequencer: FSM states,
// controller register addresses and reset values.
package irq_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACK  = 3'd1,
        ST_JUMP = 3'd2,
        ST_EOI  = 3'd3,
        ST_RET  = 3'd4
    } state_e;

    localparam logic [4:0] VIC_ADDR_STATUS = 5'b00000;
    localparam logic [4:0] VIC_ADDR_EOI    = 5'b00001;
    localparam logic [4:0] VIC_ADDR_ENABLE = 5'b00010;

    localparam state_e RST_STATE = ST_IDLE;
    localparam logic   RST_IE    = 1'b0;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_seq_stack.sv
// Context LIFO for the interrupt sequencer: {PC, flags, IE} entries.
// Push when full and pop when empty are dropped silently.
module irq_seq_stack
    import irq_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 21,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] top_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int IW    = clog2_min1(DEPTH);
    localparam int SLOTS = 1 << IW;

    logic [DW-1:0] mem_q [SLOTS];
    logic [CW-1:0] cnt_q;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage carries no reset; the counter alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[IW'(cnt_q)] <= data_i;
        end
    end

    assign top_o = empty_o ? '0 : mem_q[IW'(cnt_q - CW'(1))];

endmodule

// File: rtl/irq_seq.sv
// CPU-side interrupt sequencer: ack, vector redirect, context save/restore, EOI.
// Nesting is enabled by defining IRQ_SEQ_NEST_EN; otherwise depth is 1 and IE is auto-managed.
module irq_seq
    import irq_seq_pkg::*;
#(
    parameter int NEST_DEPTH  = 4,
    parameter int FLAG_W      = 4,
    parameter int ACK_HOLDOFF = 3
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              irq_i,
    input  logic [15:0]       irqaddr_i,
    output logic              irqack_o,
    input  logic              boundary_i,
    input  logic [15:0]       pc_i,
    input  logic [FLAG_W-1:0] flags_i,
    input  logic              reti_i,
    input  logic              ie_set_i,
    input  logic              ie_clr_i,
    output logic              stall_o,
    output logic              redirect_o,
    output logic [15:0]       redirect_pc_o,
    output logic              restore_flags_o,
    output logic [FLAG_W-1:0] flags_o,
    output logic              ie_o,
    output logic              vic_sel_o,
    output logic              vic_write_o,
    output logic [4:0]        vic_addr_o,
    output logic [15:0]       vic_data_o,
    output logic              err_o
);

`ifdef IRQ_SEQ_NEST_EN
    localparam int DEPTH = NEST_DEPTH;
`else
    localparam int DEPTH = 1;
`endif
    localparam int DW = 16 + FLAG_W + 1;
    localparam int HW = (ACK_HOLDOFF > 0) ? $clog2(ACK_HOLDOFF + 1) : 1;

    state_e            state_q, state_d;
    logic [15:0]       vec_q, vec_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              ie_q, ie_d;
    logic              err_q, err_d;
    logic              push, pop, full, empty;
    logic [DW-1:0]     top;
    logic [15:0]       pop_pc;
    logic [FLAG_W-1:0] pop_flags;
    logic              pop_ie;

    irq_seq_stack #(.DEPTH(DEPTH), .DW(DW)) u_stack (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({pc_i, flags_i, ie_q}),
        .top_o   (top),
        .full_o  (full),
        .empty_o (empty)
    );

    assign pop_pc    = top[DW-1 -: 16];
    assign pop_flags = top[FLAG_W:1];
    assign pop_ie    = top[0];

`ifdef IRQ_SEQ_NEST_EN
    logic unused_pop_ie;
    assign unused_pop_ie = pop_ie;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= RST_STATE;
            vec_q   <= '0;
            hold_q  <= '0;
            ie_q    <= RST_IE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            ie_q    <= ie_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        vec_d           = vec_q;
        hold_d          = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
        ie_d            = ie_clr_i ? 1'b0 : (ie_set_i ? 1'b1 : ie_q);
        err_d           = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        irqack_o        = 1'b0;
        stall_o         = 1'b0;
        redirect_o      = 1'b0;
        redirect_pc_o   = '0;
        restore_flags_o = 1'b0;
        flags_o         = '0;
        vic_sel_o       = 1'b0;
        vic_write_o     = 1'b0;
        vic_addr_o      = '0;
        unique case (state_q)
            ST_IDLE: begin
                // RETI takes precedence over a simultaneously takeable request.
                if (boundary_i && reti_i) begin
                    if (!empty) state_d = ST_EOI;
                    else        err_d   = 1'b1;
                end else if (irq_i && ie_q && boundary_i && hold_q == '0 && !full) begin
                    push    = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                irqack_o = 1'b1;
                stall_o  = 1'b1;
                vec_d    = irqaddr_i;
                hold_d   = HW'(ACK_HOLDOFF);
`ifndef IRQ_SEQ_NEST_EN
                ie_d     = 1'b0;
`endif
                state_d  = ST_JUMP;
            end
            ST_JUMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = vec_q;
                stall_o       = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_EOI: begin
                vic_sel_o   = 1'b1;
                vic_write_o = 1'b1;
                vic_addr_o  = VIC_ADDR_EOI;
                stall_o     = 1'b1;
                hold_d      = HW'(ACK_HOLDOFF);
                state_d     = ST_RET;
            end
            ST_RET: begin
                pop             = 1'b1;
                redirect_o      = 1'b1;
                redirect_pc_o   = pop_pc;
                restore_flags_o = 1'b1;
                flags_o         = pop_flags;
                stall_o         = 1'b1;
`ifndef IRQ_SEQ_NEST_EN
                ie_d            = pop_ie;
`endif
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ie_o       = ie_q;
    assign err_o      = err_q;
    assign vic_data_o = '0;

endmodule

// File: tb/tb_irq_seq.sv
// Directed bench for irq_seq: expected bus/redirect events are queued with their
// cycle number and a monitor pops and compares whenever the DUT shows an event.
module tb_irq_seq;

    localparam int FLAG_W = 4;
    localparam logic [3:0] K_ACK = 4'd1, K_JUMP = 4'd2, K_EOI = 4'd3,
                           K_RET = 4'd4, K_ERR = 4'd5, K_BAD = 4'd15;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              irq_i, boundary_i, reti_i, ie_set_i, ie_clr_i;
    logic [15:0]       irqaddr_i, pc_i;
    logic [FLAG_W-1:0] flags_i;
    logic              irqack_o, stall_o, redirect_o, restore_flags_o, ie_o;
    logic              vic_sel_o, vic_write_o, err_o;
    logic [15:0]       redirect_pc_o, vic_data_o;
    logic [FLAG_W-1:0] flags_o;
    logic [4:0]        vic_addr_o;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [39:0] exp_q[$];

    irq_seq #(.NEST_DEPTH(4), .FLAG_W(FLAG_W), .ACK_HOLDOFF(3)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .irq_i           (irq_i),
        .irqaddr_i       (irqaddr_i),
        .irqack_o        (irqack_o),
        .boundary_i      (boundary_i),
        .pc_i            (pc_i),
        .flags_i         (flags_i),
        .reti_i          (reti_i),
        .ie_set_i        (ie_set_i),
        .ie_clr_i        (ie_clr_i),
        .stall_o         (stall_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .restore_flags_o (restore_flags_o),
        .flags_o         (flags_o),
        .ie_o            (ie_o),
        .vic_sel_o       (vic_sel_o),
        .vic_write_o     (vic_write_o),
        .vic_addr_o      (vic_addr_o),
        .vic_data_o      (vic_data_o),
        .err_o           (err_o)
    );

    // Clock/reset
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [39:0] ev(input int c, input logic [3:0] k,
                                       input logic [15:0] d, input logic [3:0] f);
        return {c[15:0], k, d, f};
    endfunction

    task automatic push_exp(input int c, input logic [3:0] k,
                            input logic [15:0] d, input logic [3:0] f);
        exp_q.push_back(ev(c, k, d, f));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic take(input logic [15:0] vec, input logic [15:0] pc, input logic [3:0] fl);
        irq_i = 1'b1; irqaddr_i = vec; pc_i = pc; flags_i = fl; boundary_i = 1'b1;
        push_exp(cyc + 1, K_ACK, 16'h0000, 4'h0);
        push_exp(cyc + 2, K_JUMP, vec, 4'h0);
        repeat (5) step();  // irq stays high through the controller's mask propagation
        irq_i = 1'b0; boundary_i = 1'b0;
    endtask

    task automatic reti(input logic [15:0] ret_pc, input logic [3:0] ret_fl);
        reti_i = 1'b1; boundary_i = 1'b1;
        push_exp(cyc + 1, K_EOI, 16'h0001, 4'h0);
        push_exp(cyc + 2, K_RET, ret_pc, ret_fl);
        step();
        reti_i = 1'b0; boundary_i = 1'b0;
        repeat (4) step();
    endtask

    task automatic pulse_ie(input logic set, input logic clr);
        ie_set_i = set; ie_clr_i = clr;
        step();
        ie_set_i = 1'b0; ie_clr_i = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        logic [5:0]  sig;
        logic [3:0]  k;
        logic [15:0] d;
        logic [3:0]  f;
        logic [39:0] act, exp;
        sig = {irqack_o, redirect_o, restore_flags_o, vic_sel_o, vic_write_o, err_o};
        if (sig != 6'b0) begin
            k = K_BAD; d = 16'h0; f = 4'h0;
            case (sig)
                6'b100000: if (stall_o) k = K_ACK;
                6'b010000: if (stall_o) begin k = K_JUMP; d = redirect_pc_o; end
                6'b011000: if (stall_o) begin k = K_RET; d = redirect_pc_o; f = flags_o; end
                6'b000110: if (stall_o && vic_data_o == 16'h0) begin k = K_EOI; d = {11'b0, vic_addr_o}; end
                6'b000001: if (!stall_o) k = K_ERR;
                default:   k = K_BAD;
            endcase
            act = ev(cyc, k, d, f);
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL event: unexpected event %h (sig %b) at cycle %0d", act, sig, cyc);
            end else begin
                exp = exp_q.pop_front();
                if (act == exp) pass_cnt++;
                else $display("FAIL event: got %h expected %h at cycle %0d", act, exp, cyc);
            end
        end
    end

    initial begin
        rstn_i = 1'b0; irq_i = 1'b0; boundary_i = 1'b0; reti_i = 1'b0;
        ie_set_i = 1'b0; ie_clr_i = 1'b0; irqaddr_i = '0; pc_i = '0; flags_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        @(negedge clk_i);
        chk("rst_irqack", irqack_o, 0);
        chk("rst_redirect", redirect_o, 0);
        chk("rst_redirect_pc", redirect_pc_o, 0);
        chk("rst_restore", restore_flags_o, 0);
        chk("rst_flags", flags_o, 0);
        chk("rst_ie", ie_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_vic_sel", vic_sel_o, 0);
        chk("rst_vic_write", vic_write_o, 0);
        chk("rst_vic_addr", vic_addr_o, 0);
        chk("rst_vic_data", vic_data_o, 0);
        chk("rst_err", err_o, 0);

        // Request with IE clear is never taken
        step();
        irq_i = 1'b1; irqaddr_i = 16'h0120; boundary_i = 1'b1;
        repeat (4) step();
        irq_i = 1'b0; boundary_i = 1'b0;
        chk("ie_still_clear", ie_o, 0);
        pulse_ie(1'b1, 1'b0);
        chk("ie_after_ei", ie_o, 1);

        // Basic entry
        take(16'h0120, 16'h0040, 4'hA);
`ifdef IRQ_SEQ_NEST_EN
        chk("ie_kept_on_entry", ie_o, 1);
        take(16'h0200, 16'h0124, 4'h5);
        reti(16'h0124, 4'h5);
        reti(16'h0040, 4'hA);
        chk("ie_kept_on_exit", ie_o, 1);
`else
        chk("ie_cleared_on_entry", ie_o, 0);
        pulse_ie(1'b1, 1'b0);
        chk("ei_in_isr", ie_o, 1);
        irq_i = 1'b1; irqaddr_i = 16'h0200; boundary_i = 1'b1;
        repeat (6) step();  // depth full: must not be taken
        pulse_ie(1'b0, 1'b1);
        chk("di_in_isr", ie_o, 0);
        irq_i = 1'b0; boundary_i = 1'b0;
        reti(16'h0040, 4'hA);
        chk("ie_restored_on_exit", ie_o, 1);
`endif
        pulse_ie(1'b1, 1'b1);
        chk("ie_clr_priority", ie_o, 0);
        pulse_ie(1'b1, 1'b0);
        chk("ie_set_again", ie_o, 1);

        // RETI together with a takeable request: EOI first, request retaken after holdoff
        take(16'h0300, 16'h0050, 4'h3);
        pulse_ie(1'b1, 1'b0);
        irq_i = 1'b1; irqaddr_i = 16'h0400; pc_i = 16'h0060; flags_i = 4'h6;
        reti_i = 1'b1; boundary_i = 1'b1;
        push_exp(cyc + 1, K_EOI, 16'h0001, 4'h0);
        push_exp(cyc + 2, K_RET, 16'h0050, 4'h3);
        push_exp(cyc + 6, K_ACK, 16'h0000, 4'h0);
        step();
        reti_i = 1'b0;
        repeat (6) step();

        // Reset during JUMP aborts the redirect and empties the LIFO
        rstn_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_redirect", redirect_o, 0);
        chk("midrst_stall", stall_o, 0);
        chk("midrst_ie", ie_o, 0);
        step();
        step();
        rstn_i = 1'b1;
        repeat (6) step();
        chk("post_rst_ie", ie_o, 0);
        push_exp(cyc + 2, K_ACK, 16'h0000, 4'h0);
        push_exp(cyc + 3, K_JUMP, 16'h0400, 4'h0);
        pulse_ie(1'b1, 1'b0);
        repeat (4) step();
        irq_i = 1'b0; boundary_i = 1'b0;
`ifdef IRQ_SEQ_NEST_EN
        chk("post_rst_entry_ie", ie_o, 1);
`else
        chk("post_rst_entry_ie", ie_o, 0);
`endif
        reti(16'h0060, 4'h6);

        // Spurious RETI with empty LIFO
        reti_i = 1'b1; boundary_i = 1'b1;
        push_exp(cyc + 1, K_ERR, 16'h0000, 4'h0);
        step();
        reti_i = 1'b0; boundary_i = 1'b0;
        repeat (4) step();

        chk("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/irq_seq.md
# irq_seq

CPU-side interrupt sequencer, the initiator-side counterpart of the vectored interrupt controller. It sits inside the uC core, between the fetch/branch control and the controller. It samples the controller's request and vector, returns the one-cycle acknowledge, and saves PC and flags on a LIFO. It redirects fetch to the vector, and on RETI it issues the end-of-interrupt write to the controller's index register before restoring the saved context.

## Interface
- NEST_DEPTH, 4, LIFO depth (max nesting); forced to 1 when IRQ_SEQ_NEST_EN is undefined
- FLAG_W, 4, width of saved core flags
- ACK_HOLDOFF, 3, cycles `irq_i` is ignored after an ack or EOI, covering controller mask propagation
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- irq_i  in  1  interrupt request from controller
- irqaddr_i  in  16  vector address from controller
- irqack_o  out  1  one-cycle acknowledge to controller
- boundary_i  in  1  core at instruction boundary; redirect may be accepted
- pc_i  in  16  PC of next instruction to execute (return address)
- flags_i  in  FLAG_W  current core flags
- reti_i  in  1  RETI decoded, valid at boundary
- ie_set_i / ie_clr_i  in  1 each  EI / DI instructions
- stall_o  out  1  hold core pipeline
- redirect_o  out  1  load PC from `redirect_pc_o` this cycle
- redirect_pc_o  out  16  target PC
- restore_flags_o  out  1  load core flags from `flags_o` this cycle
- flags_o  out  FLAG_W  restored flags
- ie_o  out  1  global interrupt enable
- vic_sel_o, vic_write_o  out  1 each  controller bus strobes
- vic_addr_o  out  5  controller register address
- vic_data_o  out  16  controller write data (always 0)
- err_o  out  1  one-cycle pulse on RETI with empty LIFO

## Operation
- States: IDLE, ACK, JUMP, EOI, RET.
- IDLE takes an interrupt when `irq_i & ie_o & boundary_i & holdoff==0 & depth<NEST_DEPTH & ~reti_i`.
  - On take: push {pc_i, flags_i}, next state ACK.
- ACK:
  - Drives irqack_o=1 and stall_o=1.
  - Latches irqaddr_i into vector register.
  - Loads holdoff=ACK_HOLDOFF.
  - Next state JUMP.
- JUMP: redirect_o=1, redirect_pc_o=vector, stall_o=1, then IDLE.
- RETI in IDLE with `boundary_i & reti_i`:
  - depth>0: next state EOI.
  - depth==0: err_o pulse, no bus write, no redirect, stay IDLE.
- EOI:
  - Drives vic_sel_o=vic_write_o=1, vic_addr_o=5'b00001, stall_o=1.
  - The controller clears its highest active mask bit.
  - Loads holdoff=ACK_HOLDOFF.
  - Next state RET.
- RET:
  - Pops the LIFO.
  - redirect_o=1 with popped PC.
  - restore_flags_o=1 with popped flags.
  - stall_o=1, then IDLE.
- The holdoff counter decrements to 0 and saturates there.
- Pending request with a full LIFO: no ack is issued; the request stays pending at the controller.
- IE: ie_clr_i has priority over ie_set_i. Interrupt entry/exit effect on IE depends on configuration.
- Bus strobes are 0 outside EOI.
- Simultaneous reti_i and a takeable interrupt: RETI wins; the interrupt is re-evaluated after holdoff expires.

## Timing
- Reset values:
  - all outputs 0, including ie_o=0
  - state IDLE, depth 0, holdoff 0
- Reset mid-sequence aborts and empties the LIFO; no partial ack or EOI is emitted after release.
- Entry latency: take decision at cycle T, irqack_o at T+1, redirect_o at T+2.
  - First ISR instruction fetched from T+3 at the earliest.
- Exit latency: reti_i at T, EOI write at T+1, redirect_o and restore_flags_o at T+2.
- irqack_o and the EOI write are exactly one cycle each and never in the same cycle.
- irqaddr_i is sampled only in ACK; the controller holds the vector stable until its mask propagates, at least 2 cycles after ack.
- All outputs are registered from state, except err_o, which is registered on the decision cycle.

## Configuration
- IRQ_SEQ_NEST_EN defined:
  - LIFO depth NEST_DEPTH.
  - IE is left unchanged on entry and exit.
  - Higher-priority interrupts may preempt an ISR, since the controller masks equal and lower priorities.
- IRQ_SEQ_NEST_EN undefined:
  - Depth fixed at 1.
  - Entry clears ie_o in the ACK cycle.
  - RET sets ie_o back to its value at entry, saved alongside flags.
  - EI inside the ISR is still honoured but cannot cause a take while depth==1.

## Structure
- Package irq_seq_pkg: state enumeration; controller address constants (index/EOI 5'b00001, status 5'b00000, enable 5'b00010); reset constants.
- One sub-module, irq_seq_stack:
  - synchronous LIFO of {16-bit PC, FLAG_W flags, 1-bit IE}, NEST_DEPTH entries
  - push/pop strobes, full/empty flags
  - depth counter of width ceil_log2(NEST_DEPTH+1)
  - push on full and pop on empty are ignored

## Test plan
- ie set, irq_i=1, irqaddr_i=16'h0120, pc_i=16'h0040, boundary_i=1 -> irqack_o pulse at T+1; redirect_o with 16'h0120 at T+2; one LIFO entry.
- RETI inside that ISR -> write to addr 5'b00001 at T+1; redirect to 16'h0040 with original flags at T+2; depth 0.
- NEST_EN, depth 1, new irq vector 16'h0200 after holdoff -> second ack, depth 2; two RETIs return 16'h0200-ISR PC then 16'h0040.
- irq_i held high for 3 cycles after ack (mask propagation) -> no second irqack_o.
- Spurious RETI with empty LIFO -> err_o pulse; no bus write, no redirect. reti_i together with irq_i -> EOI first, interrupt not acked in that cycle.
- rstn_i low during JUMP -> all outputs 0, depth 0; irq_i still high after release but ie_o=0 -> no ack until EI.
